shift_sequencer: RTL and testbench

Multi-cycle controller for the shift datapath of the multicycle CPU. It drives the select of the shift-source mux (`SLLSrcA`: A / imediato / B / zero) and captures the mux output. It performs a 1-bit-per-cycle logical or arithmetic shift by a latched amount, then returns the result with a `done` pulse to the main control FSM. It replaces direct control-unit sequencing of the shift register for SLL/SRL/SRA, their variable forms, and LUI.

---
 rtl/shift_sequencer.sv | 112 +++++++++++
 tb/tb_shift_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle controller for the CPU shift datapath: selects the shift source,
// captures it, shifts one bit per cycle by a latched amount, and returns the result.
module shift_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [31:0] A,
    input  logic [31:0] mux_in,
    output logic [1:0]  SLLSrcA,
    output logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] sr;
    logic [31:0] sr_next;
    logic [4:0]  cnt;
    logic [4:0]  amt;
    logic        dir_left;
    logic        arith;

    // Only A[4:0] carries a shift amount; the upper bits are intentionally ignored.
    logic unused_a_hi;
    assign unused_a_hi = ^A[31:5];

    always_comb begin
        sr_next = sr;
        if (dir_left)
            sr_next = {sr[30:0], 1'b0};
        else
            sr_next = {arith & sr[31], sr[31:1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            amt      <= '0;
            dir_left <= 1'b0;
            arith    <= 1'b0;
            result   <= '0;
            SLLSrcA  <= 2'b11;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (funct == 3'b111) begin
                            err <= 1'b1;
                        end else begin
                            state    <= LOAD;
                            busy     <= 1'b1;
                            dir_left <= (funct == 3'b000) || (funct == 3'b011) || (funct == 3'b110);
                            arith    <= (funct == 3'b010) || (funct == 3'b101);
                            SLLSrcA  <= (funct == 3'b110) ? 2'b01 : 2'b10;
                            if (funct == 3'b110)
                                amt <= 5'd16;
                            else if (funct >= 3'b011)
                                amt <= A[4:0];
                            else
                                amt <= shamt;
                        end
                    end
                end
                LOAD: begin
                    sr  <= mux_in;
                    cnt <= amt;
                    if (amt == 5'd0) begin
                        // Zero-amount ops complete without entering SHIFT.
                        state  <= DONE;
                        result <= mux_in;
                        done   <= 1'b1;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= sr_next;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state  <= DONE;
                        result <= sr_next;
                        done   <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    SLLSrcA <= 2'b11;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural source mux and
// hand-computed expected results and latencies.
module tb_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] imm;
    logic [31:0] mux_in;
    logic [1:0]  SLLSrcA;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    shift_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .funct   (funct),
        .shamt   (shamt),
        .A       (A),
        .mux_in  (mux_in),
        .SLLSrcA (SLLSrcA),
        .result  (result),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (SLLSrcA)
            2'b00:   mux_in = A;
            2'b01:   mux_in = imm;
            2'b10:   mux_in = B;
            default: mux_in = 32'h0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one op, checks the LOAD-cycle outputs, then waits for done.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [4:0] sa,
                          input logic [1:0] exp_sel, input int exp_lat,
                          input logic [31:0] exp_res);
        int n;
        funct = f;
        shamt = sa;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        check({tag, "_load_busy"}, {31'b0, busy}, 32'd1);
        check({tag, "_load_sel"}, {30'b0, SLLSrcA}, {30'b0, exp_sel});
        while (!done && n < 40) begin
            tick();
            n++;
            if (n == 2 && exp_lat > 2)
                check({tag, "_shift_sel"}, {30'b0, SLLSrcA}, {30'b0, exp_sel});
        end
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_result"}, result, exp_res);
        tick();
        check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
        check({tag, "_sel_after"}, {30'b0, SLLSrcA}, 32'd3);
    endtask

    initial begin
        int dcount;
        reset = 1'b1;
        start = 1'b0;
        funct = 3'b000;
        shamt = 5'd0;
        A     = 32'h0;
        B     = 32'h0;
        imm   = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_sel", {30'b0, SLLSrcA}, 32'd3);
        check("rst_result", result, 32'h0);

        B = 32'h0000_0001;
        run_op("sll4", 3'b000, 5'd4, 2'b10, 6, 32'h0000_0010);

        B = 32'h8000_0000;
        A = 32'hFFFF_FFE3;
        run_op("srav3", 3'b101, 5'd0, 2'b10, 5, 32'hF000_0000);
        run_op("srlv3", 3'b100, 5'd0, 2'b10, 5, 32'h1000_0000);

        imm = 32'h0000_ABCD;
        run_op("lui", 3'b110, 5'd0, 2'b01, 18, 32'hABCD_0000);

        B = 32'h0000_0001;
        run_op("sll31", 3'b000, 5'd31, 2'b10, 33, 32'h8000_0000);
        B = 32'h8000_0000;
        run_op("sra31", 3'b010, 5'd31, 2'b10, 33, 32'hFFFF_FFFF);

        // SRL by 0 with a second start raised during LOAD.
        B     = 32'h1234_5678;
        funct = 3'b001;
        shamt = 5'd0;
        start = 1'b1;
        tick();
        funct = 3'b000;
        shamt = 5'd5;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) start = 1'b0;
            if (done) begin
                dcount++;
                if (dcount == 1) begin
                    check("srl0_latency", i + 1, 2);
                    check("srl0_result", result, 32'h1234_5678);
                end
            end
            tick();
        end
        start = 1'b0;
        check("srl0_single_done", dcount, 1);
        check("srl0_idle", {31'b0, busy}, 32'd0);

        // Illegal funct
        funct = 3'b111;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ill_err", {31'b0, err}, 32'd1);
        check("ill_busy", {31'b0, busy}, 32'd0);
        check("ill_done", {31'b0, done}, 32'd0);
        check("ill_result", result, 32'h1234_5678);
        tick();
        check("ill_err_clear", {31'b0, err}, 32'd0);
        check("ill_busy2", {31'b0, busy}, 32'd0);
        B = 32'h0000_0001;
        run_op("sll_after_ill", 3'b000, 5'd4, 2'b10, 6, 32'h0000_0010);

        // Reset during the third SHIFT cycle of SLL by 20.
        B     = 32'h0000_0003;
        funct = 3'b000;
        shamt = 5'd20;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("rstmid_busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_busy", {31'b0, busy}, 32'd0);
        check("rstmid_result", result, 32'h0);
        check("rstmid_sel", {30'b0, SLLSrcA}, 32'd3);
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) dcount++;
            tick();
        end
        check("rstmid_no_done", dcount, 0);

        // Reset and start together: reset wins.
        funct = 3'b000;
        shamt = 5'd2;
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_busy", {31'b0, busy}, 32'd0);
        check("rst_start_sel", {30'b0, SLLSrcA}, 32'd3);
        tick();
        check("rst_start_busy2", {31'b0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
